serial_adder_ctrl: RTL and testbench



---
 rtl/serial_adder_ctrl.sv | 139 +++++++++++++
 tb/tb_serial_adder_ctrl.sv | 256 +++++++++++++++++++++++++
 2 files changed

// File: rtl/serial_adder_ctrl.sv
// rtl/serial_adder_ctrl.sv - bit-serial add/subtract controller around one full-adder cell
module serial_adder_ctrl #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             sub,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf
);

    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] a_sh_q, a_sh_d;
    logic [WIDTH-1:0] b_sh_q, b_sh_d;
    logic [WIDTH-1:0] res_q, res_d;
    logic [WIDTH-1:0] sum_q, sum_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             carry_q, carry_d;
    logic             cout_q, cout_d;
    logic             ovf_q, ovf_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;

    logic             s_bit;
    logic             c_bit;
    logic             c_msb;
    logic [WIDTH-1:0] s_ext;
    logic [WIDTH-1:0] res_shift;

    always_comb begin
        // The single full-adder cell, fed from the LSBs of the operand shifters
        s_bit = a_sh_q[0] ^ b_sh_q[0] ^ carry_q;
        c_bit = (a_sh_q[0] & b_sh_q[0]) | (a_sh_q[0] & carry_q) | (b_sh_q[0] & carry_q);
        c_msb = carry_q;

        // Built this way so WIDTH=1 needs no zero-width slice
        s_ext            = '0;
        s_ext[WIDTH-1]   = s_bit;
        res_shift        = (res_q >> 1) | s_ext;

        state_d = state_q;
        a_sh_d  = a_sh_q;
        b_sh_d  = b_sh_q;
        res_d   = res_q;
        sum_d   = sum_q;
        cnt_d   = cnt_q;
        carry_d = carry_q;
        cout_d  = cout_q;
        ovf_d   = ovf_q;
        busy_d  = busy_q;
        done_d  = 1'b0;

        case (state_q)
            IDLE: begin
                if (start) begin
                    a_sh_d  = a;
                    b_sh_d  = sub ? ~b : b;
                    carry_d = sub;
                    cnt_d   = '0;
                    res_d   = '0;
                    busy_d  = 1'b1;
                    state_d = RUN;
                end
            end
            RUN: begin
                a_sh_d  = a_sh_q >> 1;
                b_sh_d  = b_sh_q >> 1;
                res_d   = res_shift;
                carry_d = c_bit;
                cnt_d   = cnt_q + CW'(1);
                if (cnt_q == LAST) begin
                    sum_d   = res_shift;
                    cout_d  = c_bit;
                    ovf_d   = c_bit ^ c_msb;
                    done_d  = 1'b1;
                    state_d = DONE;
                end
            end
            DONE: begin
                busy_d  = 1'b0;
                state_d = IDLE;
            end
            default: begin
                busy_d  = 1'b0;
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            a_sh_q  <= '0;
            b_sh_q  <= '0;
            res_q   <= '0;
            sum_q   <= '0;
            cnt_q   <= '0;
            carry_q <= 1'b0;
            cout_q  <= 1'b0;
            ovf_q   <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            a_sh_q  <= a_sh_d;
            b_sh_q  <= b_sh_d;
            res_q   <= res_d;
            sum_q   <= sum_d;
            cnt_q   <= cnt_d;
            carry_q <= carry_d;
            cout_q  <= cout_d;
            ovf_q   <= ovf_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign busy = busy_q;
    assign done = done_q;
    assign sum  = sum_q;
    assign cout = cout_q;
    assign ovf  = ovf_q;

endmodule

// File: tb/tb_serial_adder_ctrl.sv
// tb/tb_serial_adder_ctrl.sv - randomized self-checking bench for serial_adder_ctrl
module tb_serial_adder_ctrl;

    logic       clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst, start, sub;
    logic [7:0] a, b, sum;
    logic       busy, done, cout, ovf;

    logic       start1, sub1;
    logic [0:0] a1, b1, sum1;
    logic       busy1, done1, cout1, ovf1;

    serial_adder_ctrl #(.WIDTH(8)) u_dut (
        .clk(clk), .rst(rst), .start(start), .sub(sub), .a(a), .b(b),
        .busy(busy), .done(done), .sum(sum), .cout(cout), .ovf(ovf)
    );

    serial_adder_ctrl #(.WIDTH(1)) u_dut1 (
        .clk(clk), .rst(rst), .start(start1), .sub(sub1), .a(a1), .b(b1),
        .busy(busy1), .done(done1), .sum(sum1), .cout(cout1), .ovf(ovf1)
    );

    int n_cmp = 0;
    int n_bad = 0;

    logic [7:0] r_sum;
    logic       r_cout, r_ovf, r_busy0, r_done_next, r_busy_next, r_stable;
    int         r_lat;

    // Reference: plain integer arithmetic plus sign-rule overflow, result packed as {ovf, cout, sum}
    function automatic logic [33:0] ref_op(input int w, input logic [31:0] x, input logic [31:0] y,
                                           input logic s);
        longint unsigned mask, yy, full;
        logic [31:0] res;
        logic c, o, sx, sy, sr;
        mask = (64'd1 << w) - 64'd1;
        yy   = s ? ((~{32'd0, y}) & mask) : ({32'd0, y} & mask);
        full = ({32'd0, x} & mask) + yy + {63'd0, s};
        res  = full[31:0] & mask[31:0];
        c    = full[w];
        sx   = x[w-1];
        sy   = y[w-1];
        sr   = res[w-1];
        o    = s ? ((sx != sy) && (sr != sx)) : ((sx == sy) && (sr != sx));
        return {o, c, res};
    endfunction

    // Issues one operation starting at the current negedge; leaves results in r_* and
    // returns at the negedge where IDLE is visible again.
    task automatic run_op(input logic [7:0] xa, input logic [7:0] xb, input logic xs,
                          input int inject_at);
        logic [7:0] prev;
        prev  = sum;
        a     = xa;
        b     = xb;
        sub   = xs;
        start = 1'b1;
        @(negedge clk);
        start    = 1'b0;
        a        = 8'($urandom);
        b        = 8'($urandom);
        sub      = 1'($urandom);
        r_busy0  = busy;
        r_stable = 1'b1;
        r_lat    = 0;
        while (!done && r_lat < 40) begin
            if (sum !== prev) r_stable = 1'b0;
            if (r_lat == inject_at) begin
                start = 1'b1;
                a     = 8'hAA;
                b     = 8'h55;
            end
            @(negedge clk);
            start = 1'b0;
            r_lat++;
        end
        r_sum  = sum;
        r_cout = cout;
        r_ovf  = ovf;
        @(negedge clk);
        r_done_next = done;
        r_busy_next = busy;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(negedge clk);
        n_cmp += 6;
        if (busy !== 1'b0) begin n_bad++; $display("FAIL reset_busy got %b want 0", busy); end
        if (done !== 1'b0) begin n_bad++; $display("FAIL reset_done got %b want 0", done); end
        if (sum !== 8'h00) begin n_bad++; $display("FAIL reset_sum got %h want 00", sum); end
        if (cout !== 1'b0) begin n_bad++; $display("FAIL reset_cout got %b want 0", cout); end
        if (ovf !== 1'b0) begin n_bad++; $display("FAIL reset_ovf got %b want 0", ovf); end
        if (busy1 !== 1'b0 || sum1 !== 1'b0) begin
            n_bad++; $display("FAIL reset_w1 got busy=%b sum=%b want 0 0", busy1, sum1);
        end
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_directed();
        logic [7:0] ta [4] = '{8'h3C, 8'hFF, 8'h05, 8'h80};
        logic [7:0] tb [4] = '{8'h51, 8'h01, 8'h07, 8'h01};
        logic       ts [4] = '{1'b0, 1'b0, 1'b1, 1'b1};
        logic [7:0] es [4] = '{8'h8D, 8'h00, 8'hFE, 8'h7F};
        logic       ec [4] = '{1'b0, 1'b1, 1'b0, 1'b1};
        logic       eo [4] = '{1'b1, 1'b0, 1'b0, 1'b1};
        for (int i = 0; i < 4; i++) begin
            run_op(ta[i], tb[i], ts[i], -1);
            n_cmp += 8;
            if (r_sum !== es[i]) begin n_bad++; $display("FAIL dir%0d_sum got %h want %h", i, r_sum, es[i]); end
            if (r_cout !== ec[i]) begin n_bad++; $display("FAIL dir%0d_cout got %b want %b", i, r_cout, ec[i]); end
            if (r_ovf !== eo[i]) begin n_bad++; $display("FAIL dir%0d_ovf got %b want %b", i, r_ovf, eo[i]); end
            if (r_lat != 8) begin n_bad++; $display("FAIL dir%0d_latency got %0d want 8", i, r_lat); end
            if (r_busy0 !== 1'b1) begin n_bad++; $display("FAIL dir%0d_busy_rise got %b want 1", i, r_busy0); end
            if (r_done_next !== 1'b0) begin n_bad++; $display("FAIL dir%0d_done_width got %b want 0", i, r_done_next); end
            if (r_busy_next !== 1'b0) begin n_bad++; $display("FAIL dir%0d_busy_fall got %b want 0", i, r_busy_next); end
            if (r_stable !== 1'b1) begin n_bad++; $display("FAIL dir%0d_sum_hold got %b want 1", i, r_stable); end
        end
    endtask

    task automatic test_random();
        logic [7:0]  xa, xb;
        logic        xs;
        logic [33:0] e;
        for (int i = 0; i < 25; i++) begin
            xa = 8'($urandom);
            xb = 8'($urandom);
            xs = 1'($urandom);
            e  = ref_op(8, {24'd0, xa}, {24'd0, xb}, xs);
            run_op(xa, xb, xs, -1);
            n_cmp += 4;
            if (r_sum !== e[7:0]) begin n_bad++; $display("FAIL rnd%0d_sum %h %s %h got %h want %h", i, xa, xs ? "-" : "+", xb, r_sum, e[7:0]); end
            if (r_cout !== e[32]) begin n_bad++; $display("FAIL rnd%0d_cout got %b want %b", i, r_cout, e[32]); end
            if (r_ovf !== e[33]) begin n_bad++; $display("FAIL rnd%0d_ovf got %b want %b", i, r_ovf, e[33]); end
            if (r_lat != 8) begin n_bad++; $display("FAIL rnd%0d_latency got %0d want 8", i, r_lat); end
        end
    endtask

    task automatic test_start_while_busy();
        int extra;
        run_op(8'h10, 8'h20, 1'b0, 3);
        extra = 0;
        for (int i = 0; i < 12; i++) begin
            if (done || busy) extra++;
            @(negedge clk);
        end
        n_cmp += 4;
        if (r_sum !== 8'h30) begin n_bad++; $display("FAIL swb_sum got %h want 30", r_sum); end
        if (r_lat != 8) begin n_bad++; $display("FAIL swb_latency got %0d want 8", r_lat); end
        if (extra != 0) begin n_bad++; $display("FAIL swb_queued got %0d active cycles want 0", extra); end
        run_op(8'h40, 8'h02, 1'b0, -1);
        if (r_sum !== 8'h42) begin n_bad++; $display("FAIL swb_next_sum got %h want 42", r_sum); end
    endtask

    task automatic test_reset_mid_op();
        int pulses;
        a     = 8'hFF;
        b     = 8'hFF;
        sub   = 1'b0;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (4) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        n_cmp += 7;
        if (busy !== 1'b0) begin n_bad++; $display("FAIL rmid_busy got %b want 0", busy); end
        if (done !== 1'b0) begin n_bad++; $display("FAIL rmid_done got %b want 0", done); end
        if (sum !== 8'h00) begin n_bad++; $display("FAIL rmid_sum got %h want 00", sum); end
        if (cout !== 1'b0 || ovf !== 1'b0) begin n_bad++; $display("FAIL rmid_flags got cout=%b ovf=%b want 0 0", cout, ovf); end
        rst    = 1'b0;
        pulses = 0;
        for (int i = 0; i < 15; i++) begin
            @(negedge clk);
            if (done) pulses++;
        end
        if (pulses != 0) begin n_bad++; $display("FAIL rmid_no_done got %0d pulses want 0", pulses); end
        run_op(8'h01, 8'h01, 1'b0, -1);
        if (r_sum !== 8'h02) begin n_bad++; $display("FAIL rmid_fresh_sum got %h want 02", r_sum); end
        if (r_lat != 8) begin n_bad++; $display("FAIL rmid_fresh_latency got %0d want 8", r_lat); end
    endtask

    task automatic test_back_to_back();
        logic [7:0]  xa [2];
        logic [7:0]  xb [2];
        logic        xs [2];
        logic [33:0] e;
        for (int i = 0; i < 2; i++) begin
            xa[i] = 8'($urandom);
            xb[i] = 8'($urandom);
            xs[i] = 1'($urandom);
        end
        for (int i = 0; i < 2; i++) begin
            e = ref_op(8, {24'd0, xa[i]}, {24'd0, xb[i]}, xs[i]);
            run_op(xa[i], xb[i], xs[i], -1);
            n_cmp += 3;
            if (r_sum !== e[7:0]) begin n_bad++; $display("FAIL b2b%0d_sum got %h want %h", i, r_sum, e[7:0]); end
            if ({r_ovf, r_cout} !== e[33:32]) begin n_bad++; $display("FAIL b2b%0d_flags got %b%b want %b", i, r_ovf, r_cout, e[33:32]); end
            if (r_lat != 8) begin n_bad++; $display("FAIL b2b%0d_latency got %0d want 8", i, r_lat); end
        end
    endtask

    task automatic test_width1();
        logic        vs [6] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
        logic        va [6] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0};
        logic        vb [6] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1};
        logic [33:0] e;
        int          lat;
        for (int i = 0; i < 6; i++) begin
            e      = ref_op(1, {31'd0, va[i]}, {31'd0, vb[i]}, vs[i]);
            a1     = va[i];
            b1     = vb[i];
            sub1   = vs[i];
            start1 = 1'b1;
            @(negedge clk);
            start1 = 1'b0;
            lat    = 0;
            while (!done1 && lat < 10) begin
                @(negedge clk);
                lat++;
            end
            n_cmp += 4;
            if (sum1 !== e[0]) begin n_bad++; $display("FAIL w1_%0d_sum got %b want %b", i, sum1, e[0]); end
            if (cout1 !== e[32]) begin n_bad++; $display("FAIL w1_%0d_cout got %b want %b", i, cout1, e[32]); end
            if (ovf1 !== e[33]) begin n_bad++; $display("FAIL w1_%0d_ovf got %b want %b", i, ovf1, e[33]); end
            if (lat != 1) begin n_bad++; $display("FAIL w1_%0d_latency got %0d want 1", i, lat); end
            @(negedge clk);
        end
    endtask

    initial begin
        rst    = 1'b1;
        start  = 1'b0;
        sub    = 1'b0;
        a      = '0;
        b      = '0;
        start1 = 1'b0;
        sub1   = 1'b0;
        a1     = '0;
        b1     = '0;
        @(negedge clk);
        test_reset();
        test_directed();
        test_random();
        test_start_while_busy();
        test_reset_mid_op();
        test_back_to_back();
        test_width1();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
